// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern pixel source for the 640x480 VGA controller.
// Generates colour bars, checkerboard, a bouncing box or a solid fill from
// the controller's hcount/vcount. The output is registered, so it trails the
// scan counters by one clock. Pattern selection and box motion change only at
// the start of vertical blanking.
// Optional build macro BORDER_EN: forces a one-pixel white frame around the
// active area, overriding every pattern.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BOX_SIZE  = 64,
  parameter int unsigned SPEED     = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR  = 24'h0000FF
) (
  input  logic        Clk25M,
  input  logic        Rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [23:0] data_out,
  output logic        frame_tick,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam logic [9:0]  H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  localparam logic [10:0] XMAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YMAX  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] BOX   = 11'(BOX_SIZE);

  typedef enum logic {INC, DEC} dir_t;

  dir_t        dir_x, dir_x_nxt, dir_y, dir_y_nxt;
  logic [9:0]  box_x_nxt, box_y_nxt;
  logic [9:0]  vcount_d;
  logic [1:0]  mode_q;
  logic [23:0] pix;

  logic [10:0] x_wide, x_inc, x_dec;
  logic [10:0] y_wide, y_inc, y_dec;
  logic [10:0] h_wide, v_wide;
  logic        active;
  logic        in_box;

  // Frame tick detection, mode latch and registered pixel output.
  always_ff @(posedge Clk25M) begin
    if (Rst) begin
      data_out   <= '0;
      frame_tick <= 1'b0;
      vcount_d   <= '0;
      mode_q     <= '0;
    end else begin
      data_out   <= pix;
      vcount_d   <= vcount;
      frame_tick <= (vcount_d == V_ACT - 10'd1) && (vcount == V_ACT);
      if (frame_tick) mode_q <= mode;
    end
  end

  // Box position and direction state registers for both axes.
  always_ff @(posedge Clk25M) begin
    if (Rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= INC;
      dir_y <= INC;
    end else begin
      box_x <= box_x_nxt;
      box_y <= box_y_nxt;
      dir_x <= dir_x_nxt;
      dir_y <= dir_y_nxt;
    end
  end

  // Horizontal bounce: step once per frame, clamp at the wall and reverse.
  always_comb begin
    x_wide    = {1'b0, box_x};
    x_inc     = x_wide + SPD;
    x_dec     = x_wide - SPD;
    box_x_nxt = box_x;
    dir_x_nxt = dir_x;
    if (frame_tick) begin
      unique case (dir_x)
        INC: begin
          if (x_inc >= XMAX) begin
            box_x_nxt = XMAX[9:0];
            dir_x_nxt = DEC;
          end else begin
            box_x_nxt = x_inc[9:0];
          end
        end
        DEC: begin
          if (x_wide <= SPD) begin
            box_x_nxt = '0;
            dir_x_nxt = INC;
          end else begin
            box_x_nxt = x_dec[9:0];
          end
        end
      endcase
    end
  end

  // Vertical bounce: same rule as horizontal against the bottom limit.
  always_comb begin
    y_wide    = {1'b0, box_y};
    y_inc     = y_wide + SPD;
    y_dec     = y_wide - SPD;
    box_y_nxt = box_y;
    dir_y_nxt = dir_y;
    if (frame_tick) begin
      unique case (dir_y)
        INC: begin
          if (y_inc >= YMAX) begin
            box_y_nxt = YMAX[9:0];
            dir_y_nxt = DEC;
          end else begin
            box_y_nxt = y_inc[9:0];
          end
        end
        DEC: begin
          if (y_wide <= SPD) begin
            box_y_nxt = '0;
            dir_y_nxt = INC;
          end else begin
            box_y_nxt = y_dec[9:0];
          end
        end
      endcase
    end
  end

  // Pixel colour for the current scan position and latched mode.
  always_comb begin
    h_wide = {1'b0, hcount};
    v_wide = {1'b0, vcount};
    active = (hcount < H_ACT) && (vcount < V_ACT);
    in_box = (h_wide >= x_wide) && (h_wide < x_wide + BOX) &&
             (v_wide >= y_wide) && (v_wide < y_wide + BOX);
    pix    = '0;
    unique case (mode_q)
      2'd0: begin
        if      (hcount < 10'(BAR_W))     pix = 24'hFFFFFF;
        else if (hcount < 10'(BAR_W * 2)) pix = 24'hFFFF00;
        else if (hcount < 10'(BAR_W * 3)) pix = 24'h00FFFF;
        else if (hcount < 10'(BAR_W * 4)) pix = 24'h00FF00;
        else if (hcount < 10'(BAR_W * 5)) pix = 24'hFF00FF;
        else if (hcount < 10'(BAR_W * 6)) pix = 24'hFF0000;
        else if (hcount < 10'(BAR_W * 7)) pix = 24'h0000FF;
        else                              pix = 24'h000000;
      end
      2'd1: pix = (hcount[5] ^ vcount[5]) ? 24'hFFFFFF : 24'h000000;
      2'd2: pix = in_box ? BOX_COLOR : BG_COLOR;
      2'd3: pix = solid_rgb;
    endcase
`ifdef BORDER_EN
    if (hcount == '0 || hcount == H_ACT - 10'd1 ||
        vcount == '0 || vcount == V_ACT - 10'd1)
      pix = '1;
`endif
    if (!active) pix = '0;
  end

endmodule
